// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: carry-pipelined carry-lookahead adder/subtractor.
//
// WIDTH-bit operands are split into NSEG = WIDTH/SEG_W segments. Pipeline
// stage k resolves segment k with 4-bit lookahead groups. The groups inside a
// segment are chained by ripple. The segment carry is registered into stage
// k+1. Operand segments that have not been resolved yet travel with the op.
// Result segments that are already resolved travel with it too, so the whole
// sum leaves in one cycle. Latency is NSEG cycles. Throughput is one op per
// cycle, with full valid/ready backpressure.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid | out_ready
//   a, b                operands (WIDTH)
//   cin                 carry in for add; ignored when sub=1
//   sub                 1: a - b, 0: a + b + cin
//   sat                 (CLA_PIPE_SAT_EN only) clamp the sum on signed overflow
//   out_valid/out_ready output handshake
//   sum                 result (WIDTH)
//   cout                carry out of MSB (for sub, 1 = no borrow)
//   ovf                 signed overflow (raw, even when the sum is clamped)
//
// Optional feature: define CLA_PIPE_SAT_EN to add the sat input.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / SEG_W;
  localparam int unsigned NGRP = SEG_W / 4;

  if ((WIDTH % SEG_W) != 0 || (SEG_W % 4) != 0) begin : g_bad_params
    $error("cla_pipe_addsub: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
  end

  // The function returns carries c1..c4 as bits [0..3].
  function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                      input logic c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // The function returns {carry into segment MSB, carry out, segment sum}.
  function automatic logic [SEG_W+1:0] seg_add(input logic [SEG_W-1:0] x,
                                               input logic [SEG_W-1:0] y,
                                               input logic ci);
    logic [SEG_W-1:0] p, g;
    logic [SEG_W:0]   c;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int unsigned j = 0; j < NGRP; j++) begin
      c[4*j+1 +: 4] = cla4(p[4*j +: 4], g[4*j +: 4], c[4*j]);
    end
    return {c[SEG_W-1], c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  // Entry q[k] holds the outputs of stage k.
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             c_q [NSEG];
  logic             v_q [NSEG];
  logic             o_q [NSEG];
  logic             t_q [NSEG];

  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] s_d [NSEG];
  logic             c_d [NSEG];
  logic             v_d [NSEG];
  logic             o_d [NSEG];
  logic             t_d [NSEG];

  // Inputs presented to each stage: the ports for stage 0, else the previous register.
  logic [WIDTH-1:0] a_i [NSEG];
  logic [WIDTH-1:0] b_i [NSEG];
  logic [WIDTH-1:0] s_i [NSEG];
  logic             c_i [NSEG];
  logic             v_i [NSEG];
  logic             t_i [NSEG];

  logic en;
  logic sat_in;

`ifdef CLA_PIPE_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  assign en       = !v_q[NSEG-1] || out_ready;
  assign in_ready = en;

  always_comb begin
    logic [SEG_W+1:0] r;
    logic [WIDTH-1:0] xs;
    r      = '0;
    xs     = '0;
    a_i[0] = a;
    b_i[0] = sub ? ~b : b;
    s_i[0] = '0;
    c_i[0] = sub | cin;
    v_i[0] = in_valid;
    t_i[0] = sat_in;
    for (int unsigned k = 1; k < NSEG; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      s_i[k] = s_q[k-1];
      c_i[k] = c_q[k-1];
      v_i[k] = v_q[k-1];
      t_i[k] = t_q[k-1];
    end
    for (int unsigned k = 0; k < NSEG; k++) begin
      r  = seg_add(a_i[k][k*SEG_W +: SEG_W], b_i[k][k*SEG_W +: SEG_W], c_i[k]);
      xs = s_i[k];
      xs[k*SEG_W +: SEG_W] = r[SEG_W-1:0];
      o_d[k] = r[SEG_W+1] ^ r[SEG_W];
      // The clamp applies only in the last stage, where o_d is the true MSB overflow.
      // Operand signs are equal on overflow, so a's MSB picks the direction.
      if (k == NSEG-1 && t_i[k] && o_d[k]) begin
        xs = a_i[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
      a_d[k] = a_i[k];
      b_d[k] = b_i[k];
      s_d[k] = xs;
      c_d[k] = r[SEG_W];
      v_d[k] = v_i[k];
      t_d[k] = t_i[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
        o_q[k] <= 1'b0;
        t_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
        o_q[k] <= o_d[k];
        t_q[k] <= t_d[k];
      end
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = o_q[NSEG-1];

endmodule
